// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential/redirect next-PC with a pending-redirect latch.
// Define PC_BTB_EN to add a direct-mapped branch target buffer for next-PC prediction.
module pc_gen #(
  parameter int unsigned        ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter int unsigned        PC_STEP      = 4,
  parameter int unsigned        BTB_ENTRIES  = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              stall_in,
  input  logic              redirect_in,
  input  logic [ADDR_W-1:0] redirect_target_in,
  input  logic              upd_valid_in,
  input  logic [ADDR_W-1:0] upd_pc_in,
  input  logic [ADDR_W-1:0] upd_target_in,
  input  logic              upd_taken_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_valid_out,
  output logic              pred_taken_out,
  output logic [ADDR_W-1:0] pred_target_out
);

  localparam int unsigned       SHIFT      = $clog2(PC_STEP);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));

  typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic              hold;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

`ifdef PC_BTB_EN
  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - SHIFT - IDX_W;

  logic              btb_valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag_q    [BTB_ENTRIES];
  logic [ADDR_W-1:0] btb_target_q [BTB_ENTRIES];
  logic [1:0]        btb_ctr_q    [BTB_ENTRIES];

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              up_hit;

  assign lk_idx = pc_q[SHIFT +: IDX_W];
  assign lk_tag = pc_q[ADDR_W-1 -: TAG_W];
  assign up_idx = upd_pc_in[SHIFT +: IDX_W];
  assign up_tag = upd_pc_in[ADDR_W-1 -: TAG_W];
  assign up_hit = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

  assign pred_taken  = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag) &&
                       btb_ctr_q[lk_idx][1];
  assign pred_target = btb_target_q[lk_idx];

  // Only valid bits are reset; stale tags/targets are masked by them.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
    end else if (upd_valid_in && rdy_in) begin
      if (up_hit) begin
        if (upd_taken_in) begin
          if (btb_ctr_q[up_idx] != 2'd3) btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] + 2'd1;
          btb_target_q[up_idx] <= upd_target_in & ALIGN_MASK;
        end else if (btb_ctr_q[up_idx] != 2'd0) begin
          btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] - 2'd1;
        end
      end else if (upd_taken_in) begin
        btb_valid_q[up_idx]  <= 1'b1;
        btb_tag_q[up_idx]    <= up_tag;
        btb_target_q[up_idx] <= upd_target_in & ALIGN_MASK;
        btb_ctr_q[up_idx]    <= 2'd2;
      end
    end
  end

  logic unused_upd_pc;
  assign unused_upd_pc = ^upd_pc_in;
`else
  localparam int unsigned unused_btb_entries = BTB_ENTRIES;

  assign pred_taken  = 1'b0;
  assign pred_target = '0;

  logic unused_upd;
  assign unused_upd = ^{upd_valid_in, upd_pc_in, upd_target_in, upd_taken_in};
`endif

  assign hold = stall_in | ~rdy_in;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    unique case (state_q)
      StBoot: begin
        // Nothing advances in BOOT, so any redirect is parked for the first RUN advance.
        if (redirect_in) begin
          pend_valid_d  = 1'b1;
          pend_target_d = redirect_target_in & ALIGN_MASK;
        end
        if (rdy_in) state_d = StRun;
      end
      default: begin
        if (hold) begin
          if (redirect_in) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redirect_target_in & ALIGN_MASK;
            state_d       = StHold;
          end
        end else begin
          state_d = StRun;
          if (redirect_in) begin
            pc_d         = redirect_target_in & ALIGN_MASK;
            pend_valid_d = 1'b0;
          end else if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
          end else if (pred_taken) begin
            pc_d = pred_target;
          end else begin
            pc_d = pc_q + STEP;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= StBoot;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc_out          = pc_q;
  assign pc_valid_out    = (state_q != StBoot);
  assign pred_taken_out  = pred_taken;
  assign pred_target_out = pred_target;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios then randomized traffic against a
// behavioural model of the fetch PC, pending redirect and (with PC_BTB_EN) the BTB.
module tb_pc_gen;

  localparam int unsigned AW   = 16;
  localparam int unsigned STP  = 4;
  localparam int unsigned ENT  = 16;
  localparam logic [AW-1:0] RV   = 16'h0100;
  localparam logic [AW-1:0] MASK = 16'hFFFC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b1;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_target = '0;
  logic          upd_valid = 1'b0;
  logic [AW-1:0] upd_pc = '0;
  logic [AW-1:0] upd_target = '0;
  logic          upd_taken = 1'b0;
  logic [AW-1:0] pc;
  logic          pc_valid;
  logic          pred_taken;
  logic [AW-1:0] pred_target;

  pc_gen #(
    .ADDR_W      (AW),
    .RESET_VECTOR(RV),
    .PC_STEP     (STP),
    .BTB_ENTRIES (ENT)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .rdy_in            (rdy),
    .stall_in          (stall),
    .redirect_in       (redirect),
    .redirect_target_in(redirect_target),
    .upd_valid_in      (upd_valid),
    .upd_pc_in         (upd_pc),
    .upd_target_in     (upd_target),
    .upd_taken_in      (upd_taken),
    .pc_out            (pc),
    .pc_valid_out      (pc_valid),
    .pred_taken_out    (pred_taken),
    .pred_target_out   (pred_target)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state.
  logic [AW-1:0] m_pc;
  bit            m_boot;
  bit            m_pend;
  logic [AW-1:0] m_pend_t;
  // BTB model: per slot, the full aligned PC it remembers, its target and confidence.
  bit            b_valid [ENT];
  logic [AW-1:0] b_pc    [ENT];
  logic [AW-1:0] b_tgt   [ENT];
  int            b_conf  [ENT];

  function automatic int slot(logic [AW-1:0] a);
    return int'(a / STP) % ENT;
  endfunction

  function automatic bit model_pred(logic [AW-1:0] a);
`ifdef PC_BTB_EN
    int s = slot(a);
    return b_valid[s] && (b_pc[s] == (a & MASK)) && (b_conf[s] >= 2);
`else
    return (a != a);
`endif
  endfunction

  task automatic model_edge();
    bit h;
    bit p;
    int s;
    if (rst) begin
      m_pc = RV; m_boot = 1; m_pend = 0; m_pend_t = '0;
      for (int i = 0; i < ENT; i++) b_valid[i] = 0;
      return;
    end
    h = stall || !rdy;
    p = model_pred(m_pc);
    s = slot(m_pc);
    if (m_boot || h) begin
      if (redirect) begin m_pend = 1; m_pend_t = redirect_target & MASK; end
      if (m_boot && rdy) m_boot = 0;
    end else if (redirect) begin
      m_pc = redirect_target & MASK; m_pend = 0;
    end else if (m_pend) begin
      m_pc = m_pend_t; m_pend = 0;
    end else if (p) begin
      m_pc = b_tgt[s];
    end else begin
      m_pc = m_pc + 16'(STP);
    end
    if (upd_valid && rdy) begin
      s = slot(upd_pc);
      if (b_valid[s] && b_pc[s] == (upd_pc & MASK)) begin
        if (upd_taken) begin
          b_conf[s] = (b_conf[s] < 3) ? b_conf[s] + 1 : 3;
          b_tgt[s]  = upd_target & MASK;
        end else begin
          b_conf[s] = (b_conf[s] > 0) ? b_conf[s] - 1 : 0;
        end
      end else if (upd_taken) begin
        b_valid[s] = 1; b_pc[s] = upd_pc & MASK; b_tgt[s] = upd_target & MASK; b_conf[s] = 2;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycle(string tag);
    bit p;
    model_edge();
    @(posedge clk);
    #1;
    p = model_pred(m_pc);
    check({tag, ".pc"}, 32'(pc), 32'(m_pc));
    check({tag, ".valid"}, 32'(pc_valid), 32'(!m_boot));
    check({tag, ".pred"}, 32'(pred_taken), 32'(p));
`ifdef PC_BTB_EN
    if (p) check({tag, ".ptgt"}, 32'(pred_target), 32'(b_tgt[slot(m_pc)]));
`else
    check({tag, ".ptgt"}, 32'(pred_target), 32'h0);
`endif
  endtask

  task automatic jump(logic [AW-1:0] t);
    redirect = 1; redirect_target = t;
    cycle("jump");
    redirect = 0;
  endtask

  initial begin
    // Reset, then BOOT holds RESET_VECTOR for one extra cycle.
    cycle("reset");
    cycle("reset");
    check("reset.valid0", 32'(pc_valid), 32'h0);
    rst = 0;
    cycle("boot");
    check("boot.pc", 32'(pc), 32'h0100);
    cycle("seq1");
    check("seq1.pc", 32'(pc), 32'h0104);
    cycle("seq2");
    check("seq2.pc", 32'(pc), 32'h0108);

    // Unaligned redirect target is aligned.
    jump(16'h2002);
    check("redir.pc", 32'(pc), 32'h2000);
    cycle("redir_seq");
    check("redir_seq.pc", 32'(pc), 32'h2004);

    // Redirects during a stall are kept; latest wins.
    stall = 1;
    redirect = 1; redirect_target = 16'h0400; cycle("stall1");
    redirect_target = 16'h0800; cycle("stall2");
    redirect = 0; cycle("stall3");
    check("stall.hold", 32'(pc), 32'h2004);
    stall = 0;
    cycle("release");
    check("release.pc", 32'(pc), 32'h0800);
    cycle("release_seq");
    check("release_seq.pc", 32'(pc), 32'h0804);

    // Live redirect on stall release beats the pending target.
    stall = 1; redirect = 1; redirect_target = 16'h0800; cycle("conf_pend");
    stall = 0; redirect_target = 16'h0C00; cycle("conf_live");
    check("conflict.pc", 32'(pc), 32'h0C00);
    redirect = 0;
    cycle("conf_after");
    check("conflict.noreplay", 32'(pc), 32'h0C04);

    // Wrap modulo 2^ADDR_W, then rdy freeze with updates offered.
    jump(16'hFFF8);
    cycle("wrap1");
    cycle("wrap2");
    check("wrap.pc", 32'(pc), 32'h0000);
    rdy = 0; upd_valid = 1; upd_pc = 16'h0004; upd_target = 16'h0200; upd_taken = 1;
    cycle("frz1");
    cycle("frz2");
    check("freeze.pc", 32'(pc), 32'h0000);
    rdy = 1; upd_valid = 0;
    cycle("unfreeze");

    // BTB training at 0x40 -> 0x80, then de-training.
    upd_valid = 1; upd_pc = 16'h0040; upd_target = 16'h0080; upd_taken = 1;
    cycle("train");
    upd_valid = 0;
    jump(16'h003C);
    cycle("at40");
    cycle("after40");
    upd_valid = 1; upd_taken = 0;
    cycle("untrain1");
    cycle("untrain2");
    upd_valid = 0;
    jump(16'h003C);
    cycle("at40b");
    cycle("after40b");
    check("untrained.pc", 32'(pc), 32'h0044);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      rst             = ($urandom_range(99) == 0);
      rdy             = ($urandom_range(9) != 0);
      stall           = ($urandom_range(9) < 3);
      redirect        = ($urandom_range(9) < 2);
      redirect_target = $urandom_range(1) ? 16'($urandom_range(255)) : 16'($urandom);
      upd_valid       = ($urandom_range(2) == 0);
      upd_pc          = 16'($urandom_range(255));
      upd_target      = 16'($urandom_range(255));
      upd_taken       = ($urandom_range(2) != 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program-counter unit at the head of the fetch pipeline; drives the fetch address into IF_ID.
- Generalises the fixed 32-bit/step-4/zero-reset PC in address width, step and reset vector.
- Adds two things:
  - a pending-redirect latch, so a jump/branch redirect arriving during a stall is never lost;
  - an optional direct-mapped branch target buffer (BTB) for next-PC prediction.

Parameters:
- ADDR_W, 32, address/PC width in bits.
- RESET_VECTOR, 0, PC value presented after reset (ADDR_W bits, aligned to PC_STEP).
- PC_STEP, 4, sequential increment; power of two, >=1.
- BTB_ENTRIES, 16, BTB depth; power of two, >=2. Used only with PC_BTB_EN.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  synchronous reset, active-high.
- rdy_in  input  1  global ready; 0 freezes PC and BTB state.
- stall_in  input  1  1 = hold PC (pipeline stage-0 stall).
- redirect_in  input  1  1-cycle pulse: jump/branch resolved, load target.
- redirect_target_in  input  ADDR_W  redirect target address.
- upd_valid_in  input  1  BTB update strobe from EX.
- upd_pc_in  input  ADDR_W  PC of the resolved branch.
- upd_target_in  input  ADDR_W  resolved branch target.
- upd_taken_in  input  1  resolved direction.
- pc_out  output  ADDR_W  current fetch address.
- pc_valid_out  output  1  pc_out is a valid fetch request.
- pred_taken_out  output  1  BTB predicts taken for pc_out (combinational on pc_out).
- pred_target_out  output  ADDR_W  predicted target for pc_out (combinational).

Behaviour:
- Reset (rst_in=1 at edge):
  - pc_out=RESET_VECTOR, pc_valid_out=0, state=BOOT, pending_valid=0, pending_target=0.
  - All BTB valid bits cleared. Reset overrides every other input.
- States:
  - BOOT: first edge with rst_in=0 and rdy_in=1 -> RUN, pc_valid_out=1, pc_out unchanged (RESET_VECTOR is fetched first).
  - RUN: normal operation.
  - HOLD: stalled with pending_valid=1.
- Hold condition: h = stall_in | ~rdy_in.
- Next-PC priority in RUN/HOLD when h=0:
  1. redirect_in: load redirect_target_in.
  2. pending_valid: load pending_target.
  3. pred_taken_out: load pred_target_out.
  4. Otherwise pc_out + PC_STEP.
- Redirect and pending:
  - Taking a redirect or pending target clears pending_valid; state -> RUN.
- When h=1:
  - pc_out holds.
  - If redirect_in=1: pending_target <= redirect_target_in, pending_valid <= 1, state -> HOLD. A later redirect overwrites pending (latest wins).
  - If redirect_in=1 arrives in BOOT, it is captured into pending the same way; the state stays BOOT and the pending target is taken on the first RUN advance.
- Same-edge redirect with stall release: the live redirect beats the pending target; pending is cleared.
- Alignment: low log2(PC_STEP) bits of every loaded target are forced to 0.
- Arithmetic: sequential add wraps modulo 2^ADDR_W; no overflow flag.
- Latency: redirect_in at edge N -> pc_out = target after edge N (one cycle), unless h=1.
- pc_valid_out stays 1 after BOOT until the next reset; stall does not drop it.

Optional Feature:
- Macro: PC_BTB_EN.
- Defined: BTB of BTB_ENTRIES entries; each entry = valid, tag, target, 2-bit saturating counter.
  - Index: pc bits [log2(PC_STEP)+IDX_W-1 : log2(PC_STEP)]; tag: remaining upper bits.
  - Lookup on pc_out (combinational): pred_taken_out = hit & counter>=2; pred_target_out = entry target.
  - Update (upd_valid_in & rdy_in, registered at edge):
    - hit: counter +1 if taken / -1 if not, saturating at 3/0; target overwritten when taken.
    - miss & taken: allocate with counter=2, valid=1.
    - miss & not taken: no change.
  - Update and lookup on the same index in the same cycle: the lookup sees the old contents.
- Not defined: no BTB storage; pred_taken_out=0, pred_target_out=0, upd_* ignored; PC is purely sequential/redirect.

Test Plan:
- Reset with RESET_VECTOR=0x100, PC_STEP=4, release, no stall -> pc_valid_out=0 during reset; then pc_out 0x100, 0x100 (BOOT edge), 0x104, 0x108.
- Redirect without stall: redirect_in=1, target 0x2002 -> next cycle pc_out=0x2000 (aligned), then 0x2004.
- Lost-redirect check: stall_in=1 for 3 cycles; redirects to 0x400 then 0x800 during the stall; release -> pc_out holds during the stall, then 0x800, then 0x804.
- Same-edge conflict: pending=0x800, stall drops while redirect_in=1 to 0xC00 -> pc_out=0xC00; pending cleared, so no later jump to 0x800.
- Wrap and rdy freeze: ADDR_W=8, pc_out=0xFC -> next 0x00; with rdy_in=0 for 2 cycles, pc_out and BTB do not change.
- PC_BTB_EN:
  - Update pc=0x40, target=0x80, taken -> when pc_out reaches 0x40, pred_taken_out=1 and next pc_out=0x80.
  - Two not-taken updates -> counter=0, so pred_taken_out=0 and next pc_out after 0x40 is 0x44.
